// File: rtl/fb_pkg.sv
// Shared frame-buffer constants and the write-arbiter state type; also used by the scan-out reader.
// No logic: constants and types only.
package fb_pkg;

    localparam int ADDR_W      = 17;
    localparam int DATA_W      = 32;
    localparam int FRAME_WORDS = 76800;

    // Bit positions of the requesters in the arbiter request/grant vectors
    localparam int REQ_CAM  = 0;
    localparam int REQ_HOST = 1;

    typedef enum logic {
        LAST_CAM  = 1'b0,
        LAST_HOST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester and RAM port-A signal bundle for the frame-buffer write arbiter.
// slave = arbiter side; ready is produced combinationally from the valids, RAM outputs are registered.
interface fb_write_arbiter_if #(
    parameter int ADDR_W = fb_pkg::ADDR_W,
    parameter int DATA_W = fb_pkg::DATA_W
);
    logic              enable;
    logic              cam_valid;
    logic              cam_ready;
    logic              cam_sof;
    logic [DATA_W-1:0] cam_data;
    logic              host_valid;
    logic              host_ready;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_data;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data;
    logic              frame_done;
    logic [7:0]        frame_count;
    logic              host_err;

    modport master (
        output enable, cam_valid, cam_sof, cam_data, host_valid, host_addr, host_data,
        input  cam_ready, host_ready, ram_we, ram_addr, ram_data, frame_done, frame_count, host_err
    );

    modport slave (
        input  enable, cam_valid, cam_sof, cam_data, host_valid, host_addr, host_data,
        output cam_ready, host_ready, ram_we, ram_addr, ram_data, frame_done, frame_count, host_err
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: on a tie the requester not granted last wins.
// Grant is combinational (zero latency); state updates on each grant and holds while disabled.
module rr_arbiter2
    import fb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic [1:0] w_gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= LAST_HOST;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A grant is only ever issued to a requesting side, so every grant is a transfer
    always_comb begin
        w_state_nxt = r_state;
        if (w_gnt[REQ_CAM]) begin
            w_state_nxt = LAST_CAM;
        end else if (w_gnt[REQ_HOST]) begin
            w_state_nxt = LAST_HOST;
        end
    end

    // Reset also blocks grants so ready drops immediately on an asynchronous reset
    always_comb begin
        w_gnt = 2'b00;
        if (i_en && rst_n) begin
            if (i_req[REQ_CAM] && i_req[REQ_HOST]) begin
                if (r_state == LAST_HOST) begin
                    w_gnt[REQ_CAM] = 1'b1;
                end else begin
                    w_gnt[REQ_HOST] = 1'b1;
                end
            end else begin
                w_gnt = i_req;
            end
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer RAM port-A write controller: round-robin camera/host arbitration, frame addressing.
// Handshake in cycle N gives a registered write in N+1; ready is combinational, one write per cycle.
module fb_write_arbiter #(
    parameter int ADDR_W      = fb_pkg::ADDR_W,
    parameter int DATA_W      = fb_pkg::DATA_W,
    parameter int FRAME_WORDS = fb_pkg::FRAME_WORDS
) (
    input  logic                clk,
    input  logic                reset_n,
    fb_write_arbiter_if.slave   bus
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);
    // One extra bit so FRAME_WORDS == 2**ADDR_W is representable
    localparam logic [ADDR_W:0]   FRAME_LIM = (ADDR_W + 1)'(FRAME_WORDS);

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_cam_xfer;
    logic              w_host_xfer;
    logic [ADDR_W-1:0] w_cam_wr_addr;
    logic              w_cam_last;
    logic [ADDR_W-1:0] w_cam_addr_nxt;
    logic              w_host_in_range;

    logic [ADDR_W-1:0] r_cam_addr;
    logic              r_ram_we;
    logic [ADDR_W-1:0] r_ram_addr;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_frame_done;
    logic [7:0]        r_frame_count;
    logic              r_host_err;

    assign w_req = {bus.host_valid, bus.cam_valid};

    rr_arbiter2 u_arb (
        .clk   (clk),
        .rst_n (reset_n),
        .i_en  (bus.enable),
        .i_req (w_req),
        .o_gnt (w_gnt)
    );

    assign bus.cam_ready  = w_gnt[fb_pkg::REQ_CAM];
    assign bus.host_ready = w_gnt[fb_pkg::REQ_HOST];

    assign w_cam_xfer  = bus.cam_valid  && bus.cam_ready;
    assign w_host_xfer = bus.host_valid && bus.host_ready;

    // A start-of-frame word always restarts at 0, abandoning any partial frame
    assign w_cam_wr_addr   = bus.cam_sof ? '0 : r_cam_addr;
    assign w_cam_last      = (w_cam_wr_addr == LAST_ADDR);
    assign w_cam_addr_nxt  = w_cam_last ? '0 : w_cam_wr_addr + ADDR_W'(1);
    assign w_host_in_range = ({1'b0, bus.host_addr} < FRAME_LIM);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cam_addr    <= '0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_data    <= '0;
            r_frame_done  <= 1'b0;
            r_frame_count <= 8'd0;
            r_host_err    <= 1'b0;
        end else begin
            r_ram_we     <= 1'b0;
            r_frame_done <= 1'b0;
            r_host_err   <= 1'b0;
            if (w_cam_xfer) begin
                r_ram_we     <= 1'b1;
                r_ram_addr   <= w_cam_wr_addr;
                r_ram_data   <= bus.cam_data;
                r_cam_addr   <= w_cam_addr_nxt;
                r_frame_done <= w_cam_last;
                if (w_cam_last) begin
                    r_frame_count <= r_frame_count + 8'd1;
                end
            end else if (w_host_xfer) begin
                // Out-of-range host writes are accepted and dropped, never reaching the RAM
                r_ram_we   <= w_host_in_range;
                r_ram_addr <= bus.host_addr;
                r_ram_data <= bus.host_data;
                r_host_err <= !w_host_in_range;
            end
        end
    end

    assign bus.ram_we      = r_ram_we;
    assign bus.ram_addr    = r_ram_addr;
    assign bus.ram_data    = r_ram_data;
    assign bus.frame_done  = r_frame_done;
    assign bus.frame_count = r_frame_count;
    assign bus.host_err    = r_host_err;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Randomised and directed bench for fb_write_arbiter against a transaction-level reference model.
// Uses a shortened 8-word frame so wrap behaviour is reached quickly.
module tb_fb_write_arbiter;

    localparam int AW = 17;
    localparam int DW = 32;
    localparam int FW = 8;

    typedef struct packed {
        logic          a_cr;
        logic          a_hr;
        logic          cr;
        logic          hr;
        logic          we;
        logic          done;
        logic          err;
        logic [7:0]    fc;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } step_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    // Reference model state: who won the last transfer, next camera address, frames completed
    bit   m_last_cam;
    int   m_cam_addr;
    int   m_fc;

    fb_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();

    fb_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FRAME_WORDS(FW)) dut (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        ifc.enable     = 1'b1;
        ifc.cam_valid  = 1'b0;
        ifc.cam_sof    = 1'b0;
        ifc.cam_data   = '0;
        ifc.host_valid = 1'b0;
        ifc.host_addr  = '0;
        ifc.host_data  = '0;
    endtask

    task automatic model_reset();
        m_last_cam = 1'b0;
        m_cam_addr = 0;
        m_fc       = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Capture the DUT's ready outputs, predict this cycle's transfer, then advance past the edge
    task automatic step(output step_t s);
        bit gc;
        bit gh;
        int wa;
        #1;
        s      = '0;
        s.a_cr = ifc.cam_ready;
        s.a_hr = ifc.host_ready;
        gc = 1'b0;
        gh = 1'b0;
        if (ifc.enable) begin
            if (ifc.cam_valid && ifc.host_valid) begin
                if (m_last_cam) gh = 1'b1;
                else            gc = 1'b1;
            end else begin
                gc = ifc.cam_valid;
                gh = ifc.host_valid;
            end
        end
        s.cr = gc;
        s.hr = gh;
        if (gc) begin
            wa     = ifc.cam_sof ? 0 : m_cam_addr;
            s.we   = 1'b1;
            s.addr = AW'(wa);
            s.data = ifc.cam_data;
            if (wa == FW - 1) begin
                s.done     = 1'b1;
                m_fc       = (m_fc + 1) % 256;
                m_cam_addr = 0;
            end else begin
                m_cam_addr = wa + 1;
            end
            m_last_cam = 1'b1;
        end else if (gh) begin
            if (int'(ifc.host_addr) < FW) begin
                s.we   = 1'b1;
                s.addr = ifc.host_addr;
                s.data = ifc.host_data;
            end else begin
                s.err = 1'b1;
            end
            m_last_cam = 1'b0;
        end
        s.fc = 8'(m_fc);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n          = 1'b0;
        clear_inputs();
        ifc.cam_valid  = 1'b1;
        ifc.host_valid = 1'b1;
        #1;
        n_checks++;
        if ({ifc.cam_ready, ifc.host_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 00", {ifc.cam_ready, ifc.host_ready});
        end
        n_checks++;
        if ({ifc.ram_we, ifc.frame_done, ifc.host_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000", {ifc.ram_we, ifc.frame_done, ifc.host_err});
        end
        n_checks++;
        if ({ifc.ram_addr, ifc.ram_data, ifc.frame_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: addr %0h data %0h fc %0d want 0", ifc.ram_addr, ifc.ram_data, ifc.frame_count);
        end
        do_reset();
    endtask

    task automatic test_cam_only();
        step_t s;
        do_reset();
        ifc.cam_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ifc.cam_sof  = (i == 0);
            ifc.cam_data = (i == 0) ? 32'h0000_00A0 : $urandom;
            step(s);
            n_checks++;
            if (s.a_cr !== 1'b1 || ifc.ram_we !== 1'b1 || ifc.ram_addr !== AW'(i)) begin
                n_fail++;
                $display("FAIL cam_only[%0d]: ready %b we %b addr %0d want 1 1 %0d", i, s.a_cr, ifc.ram_we, ifc.ram_addr, i);
            end
            n_checks++;
            if (ifc.ram_data !== s.data) begin
                n_fail++;
                $display("FAIL cam_only_data[%0d]: got %h want %h", i, ifc.ram_data, s.data);
            end
        end
        ifc.cam_valid = 1'b0;
        ifc.cam_sof   = 1'b0;
    endtask

    task automatic test_contention();
        step_t s;
        do_reset();
        ifc.cam_valid  = 1'b1;
        ifc.host_valid = 1'b1;
        ifc.host_addr  = AW'(5);
        for (int i = 0; i < 8; i++) begin
            ifc.cam_sof   = (i == 0);
            ifc.cam_data  = $urandom;
            ifc.host_data = $urandom;
            step(s);
            n_checks++;
            if ({s.a_cr, s.a_hr} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
                n_fail++;
                $display("FAIL contention_grant[%0d]: got %b want %b", i, {s.a_cr, s.a_hr}, (i % 2 == 0) ? 2'b10 : 2'b01);
            end
            n_checks++;
            if (ifc.ram_we !== 1'b1 || ifc.ram_addr !== s.addr || ifc.ram_data !== s.data) begin
                n_fail++;
                $display("FAIL contention_write[%0d]: we %b addr %0h data %h want 1 %0h %h", i, ifc.ram_we, ifc.ram_addr, ifc.ram_data, s.addr, s.data);
            end
            if (i % 2 == 1) begin
                n_checks++;
                if (ifc.ram_addr !== AW'(5)) begin
                    n_fail++;
                    $display("FAIL contention_host_addr[%0d]: got %0h want 5", i, ifc.ram_addr);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_frame_wrap();
        step_t s;
        int    done_cnt;
        do_reset();
        done_cnt      = 0;
        ifc.cam_valid = 1'b1;
        for (int i = 0; i < FW + 1; i++) begin
            ifc.cam_sof  = (i == 0);
            ifc.cam_data = $urandom;
            step(s);
            done_cnt += int'(ifc.frame_done);
            n_checks++;
            if ({ifc.ram_we, ifc.frame_done, ifc.frame_count} !== {s.we, s.done, s.fc} || ifc.ram_addr !== s.addr) begin
                n_fail++;
                $display("FAIL wrap_step[%0d]: we %b done %b fc %0d addr %0d want %b %b %0d %0d", i, ifc.ram_we, ifc.frame_done, ifc.frame_count, ifc.ram_addr, s.we, s.done, s.fc, s.addr);
            end
            if (i == FW - 1) begin
                n_checks++;
                if (ifc.ram_addr !== AW'(FW - 1) || ifc.frame_done !== 1'b1 || ifc.frame_count !== 8'd1) begin
                    n_fail++;
                    $display("FAIL wrap_last: addr %0d done %b fc %0d want %0d 1 1", ifc.ram_addr, ifc.frame_done, ifc.frame_count, FW - 1);
                end
            end
            if (i == FW) begin
                n_checks++;
                if (ifc.ram_addr !== '0 || ifc.frame_done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL wrap_next: addr %0d done %b want 0 0", ifc.ram_addr, ifc.frame_done);
                end
            end
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++;
            $display("FAIL wrap_done_count: got %0d want 1", done_cnt);
        end
        clear_inputs();
    endtask

    task automatic test_host_oor();
        step_t s;
        do_reset();
        ifc.host_valid = 1'b1;
        ifc.host_addr  = AW'(FW);
        ifc.host_data  = $urandom;
        step(s);
        n_checks++;
        if (s.a_hr !== 1'b1 || ifc.ram_we !== 1'b0 || ifc.host_err !== 1'b1) begin
            n_fail++;
            $display("FAIL host_oor: ready %b we %b err %b want 1 0 1", s.a_hr, ifc.ram_we, ifc.host_err);
        end
        ifc.host_valid = 1'b0;
        step(s);
        n_checks++;
        if (ifc.host_err !== 1'b0 || ifc.ram_we !== 1'b0) begin
            n_fail++;
            $display("FAIL host_oor_pulse: err %b we %b want 0 0", ifc.host_err, ifc.ram_we);
        end
    endtask

    task automatic test_mid_sof();
        step_t s;
        do_reset();
        ifc.cam_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ifc.cam_sof  = (i == 0) || (i == 5);
            ifc.cam_data = $urandom;
            step(s);
            n_checks++;
            if (ifc.ram_addr !== s.addr || {ifc.ram_we, ifc.frame_done, ifc.frame_count} !== {s.we, s.done, s.fc}) begin
                n_fail++;
                $display("FAIL mid_sof_step[%0d]: addr %0d we %b done %b fc %0d want %0d %b %b %0d", i, ifc.ram_addr, ifc.ram_we, ifc.frame_done, ifc.frame_count, s.addr, s.we, s.done, s.fc);
            end
            if (i >= 5) begin
                n_checks++;
                if (ifc.ram_addr !== AW'(i - 5) || ifc.frame_done !== 1'b0 || ifc.frame_count !== 8'd0) begin
                    n_fail++;
                    $display("FAIL mid_sof_restart[%0d]: addr %0d done %b fc %0d want %0d 0 0", i, ifc.ram_addr, ifc.frame_done, ifc.frame_count, i - 5);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_enable();
        step_t s;
        do_reset();
        ifc.cam_valid = 1'b1;
        ifc.cam_sof   = 1'b1;
        step(s);
        ifc.cam_sof    = 1'b0;
        ifc.enable     = 1'b0;
        ifc.host_valid = 1'b1;
        ifc.host_addr  = AW'(3);
        ifc.host_data  = $urandom;
        for (int i = 0; i < 3; i++) begin
            step(s);
            n_checks++;
            if ({s.a_cr, s.a_hr, ifc.ram_we} !== 3'b000) begin
                n_fail++;
                $display("FAIL enable_off[%0d]: ready %b%b we %b want 00 0", i, s.a_cr, s.a_hr, ifc.ram_we);
            end
        end
        ifc.enable = 1'b1;
        step(s);
        n_checks++;
        if ({s.a_cr, s.a_hr} !== 2'b01 || ifc.ram_we !== 1'b1 || ifc.ram_addr !== AW'(3)) begin
            n_fail++;
            $display("FAIL enable_resume: ready %b%b we %b addr %0d want 01 1 3", s.a_cr, s.a_hr, ifc.ram_we, ifc.ram_addr);
        end
        clear_inputs();
    endtask

    task automatic test_async_reset();
        step_t s;
        do_reset();
        ifc.cam_valid  = 1'b1;
        ifc.host_valid = 1'b1;
        ifc.host_addr  = AW'(2);
        for (int i = 0; i < 5; i++) begin
            ifc.cam_sof   = (i == 0);
            ifc.cam_data  = $urandom;
            ifc.host_data = $urandom;
            step(s);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ifc.cam_ready, ifc.host_ready, ifc.ram_we, ifc.frame_done, ifc.host_err} !== 5'b0 ||
            {ifc.ram_addr, ifc.ram_data, ifc.frame_count} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: rdy %b%b we %b addr %0h data %h fc %0d want all 0", ifc.cam_ready, ifc.host_ready, ifc.ram_we, ifc.ram_addr, ifc.ram_data, ifc.frame_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            ifc.cam_data = $urandom;
            step(s);
            n_checks++;
            if ({s.a_cr, s.a_hr} !== {s.cr, s.hr} || ifc.ram_addr !== s.addr || ifc.ram_we !== s.we) begin
                n_fail++;
                $display("FAIL async_resume[%0d]: rdy %b%b addr %0d we %b want %b%b %0d %b", i, s.a_cr, s.a_hr, ifc.ram_addr, ifc.ram_we, s.cr, s.hr, s.addr, s.we);
            end
        end
        clear_inputs();
    endtask

    task automatic test_random();
        step_t s;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ifc.enable     = ($urandom_range(0, 9) != 0);
            ifc.cam_valid  = $urandom_range(0, 1) != 0;
            ifc.cam_sof    = ($urandom_range(0, 15) == 0);
            ifc.cam_data   = $urandom;
            ifc.host_valid = $urandom_range(0, 1) != 0;
            ifc.host_addr  = AW'($urandom_range(0, FW + 3));
            ifc.host_data  = $urandom;
            step(s);
            n_checks++;
            if ({s.a_cr, s.a_hr} !== {s.cr, s.hr}) begin
                n_fail++;
                $display("FAIL rand_ready[%0d]: got %b%b want %b%b", i, s.a_cr, s.a_hr, s.cr, s.hr);
            end
            n_checks++;
            if ({ifc.ram_we, ifc.frame_done, ifc.host_err, ifc.frame_count} !== {s.we, s.done, s.err, s.fc}) begin
                n_fail++;
                $display("FAIL rand_flags[%0d]: we %b done %b err %b fc %0d want %b %b %b %0d", i, ifc.ram_we, ifc.frame_done, ifc.host_err, ifc.frame_count, s.we, s.done, s.err, s.fc);
            end
            if (s.we) begin
                n_checks++;
                if (ifc.ram_addr !== s.addr || ifc.ram_data !== s.data) begin
                    n_fail++;
                    $display("FAIL rand_write[%0d]: addr %0h data %h want %0h %h", i, ifc.ram_addr, ifc.ram_data, s.addr, s.data);
                end
            end
        end
        clear_inputs();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        clear_inputs();
        model_reset();
        test_reset();
        test_cam_only();
        test_contention();
        test_frame_wrap();
        test_host_oor();
        test_mid_sof();
        test_enable();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fb_write_arbiter.md
# fb_write_arbiter

Single-clock write-port controller for the frame-buffer dual-port RAM that feeds the HDMI scan-out path. It shares RAM port A between two requesters: the camera pixel-word stream and a host/debug writer. Arbitration is round-robin. The block generates frame-relative addresses for the camera stream, wrapping at the frame end, and drives a registered write port (we/addr/data) into the RAM.

## Interface
Parameters:
- ADDR_W, 17, RAM word-address width (one 32-bit word = 4 packed 8-bit pixels)
- DATA_W, 32, RAM word width
- FRAME_WORDS, 76800, words per frame (640x480 bytes / 4); must be ≤ 2^ADDR_W

Ports:
- clk  in  1  single clock for all logic
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  0 = grant nothing; in-flight registered write still completes
- cam_valid  in  1  camera word available
- cam_ready  out  1  camera word accepted this cycle
- cam_sof  in  1  qualifies cam_data as first word of a frame
- cam_data  in  DATA_W  camera pixel word
- host_valid  in  1  host write request
- host_ready  out  1  host request accepted this cycle
- host_addr  in  ADDR_W  host target word address
- host_data  in  DATA_W  host write data
- ram_we  out  1  RAM port A write enable
- ram_addr  out  ADDR_W  RAM port A address
- ram_data  out  DATA_W  RAM port A data
- frame_done  out  1  one-cycle pulse when the last frame word is written
- frame_count  out  8  completed frames, wraps 255→0
- host_err  out  1  one-cycle pulse when a host address ≥ FRAME_WORDS is dropped

## Operation
- Handshake: a transfer occurs when valid && ready. ready is a combinational function of the valid signals, enable and the arbiter state. At most one of cam_ready and host_ready is high per cycle. valid must not depend on ready.
- Arbiter states: LAST_CAM, LAST_HOST. Reset state is LAST_HOST, so the camera wins the first tie.
  - Only one requester valid: that requester is granted.
  - Both requesters valid: grant the one not named by the state.
  - The state updates to the granted requester on every transfer. With no transfer, the state holds.
- enable=0 forces cam_ready=host_ready=0. The arbiter state holds.
- Camera addressing uses the internal counter cam_addr (reset value 0).
  - Write address = 0 if cam_sof, else cam_addr.
  - Next cam_addr = write address + 1, or 0 if write address == FRAME_WORDS-1.
  - When the write address is FRAME_WORDS-1: frame_done pulses and frame_count increments.
  - cam_sof mid-frame abandons the partial frame. There is no frame_done for the abandoned frame, and the write goes to address 0.
- Host writes:
  - host_addr < FRAME_WORDS: written as given.
  - Otherwise: the handshake still completes, ram_we stays 0 and host_err pulses.
  - Host writes never modify cam_addr.
- Arithmetic: cam_addr is ADDR_W bits unsigned. The wrap compare is exact equality to FRAME_WORDS-1, never a natural overflow. frame_count is 8-bit modulo.

## Timing
- Reset values: cam_ready=0, host_ready=0, ram_we=0, ram_addr=0, ram_data=0, frame_done=0, frame_count=0, host_err=0. cam_addr=0, arbiter state=LAST_HOST.
- Latency: a handshake in cycle N produces ram_we/ram_addr/ram_data in cycle N+1. frame_done, host_err and the frame_count update also appear in cycle N+1.
- Throughput: one write per cycle sustained. Ping-pong grants under continuous contention.
- Reset asserted mid-operation: all registers clear asynchronously. A registered write not yet presented is lost.

## Structure
- Package fb_pkg holds:
  - ADDR_W, DATA_W, FRAME_WORDS constants (shared with the scan-out reader).
  - The arbiter state enum (LAST_CAM, LAST_HOST).
- Sub-module rr_arbiter2: a two-requester round-robin arbiter containing the state register and the grant logic.
- The top level holds the camera address counter, the range check, the output register and the frame counters.

## Test plan
- Reset, then camera only: cam_sof=1 with data 0xA0, then 3 more words with no host traffic → ram writes at addr 0,1,2,3 on cycles N+1..N+4; cam_ready held high.
- Contention: both valid continuously from reset → grants alternate cam, host, cam, host…; host_addr=0x100 appears at ram_addr on every second write.
- Frame wrap with FRAME_WORDS=8 override: cam_sof then 8 words → the 8th write is at addr 7, frame_done pulses once, frame_count=1, and the next word (no sof) writes addr 0.
- Host out of range: host_addr=FRAME_WORDS → host_ready=1, ram_we=0 next cycle, host_err pulses.
- Mid-frame sof: words at 0..4, then cam_sof → write at 0, no frame_done, frame_count unchanged.
- enable=0 with both valid → no ready and no ram_we. Re-enable → the grant follows the held arbiter state. Async reset_n pulse mid-stream → all outputs 0 immediately.
